byte_unstuffer: RTL and testbench
=================================

Name: byte_unstuffer

Overview:
Decode-side counterpart of the encoder's output byte stuffer and the first stage of the JPEG decode pipeline.
- Consumes the entropy-coded stream as 16-bit words, each carrying 0-2 valid bytes.
- Removes the 0x00 inserted after every 0xFF and discards 0xFF fill bytes.
- Extracts markers and emits clean entropy-coded bytes, one per cycle, to the Huffman decoder.
- Flags end of image (EOI) and protocol errors.

Parameters:
MARKER_PREFIX, 8'hFF, byte that introduces a stuffed byte or a marker
EOI_CODE, 8'hD9, marker code that terminates the image

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
in  input  16  stuffed bytes, first byte in [15:8], second in [7:0]
in_valid  input  2  valid bytes in word: 0, 1 ([15:8] only), 2 (both); 3 illegal
ena_in  input  1  upstream word valid
rdy_out  output  1  block can accept a word this cycle
out  output  8  unstuffed data byte
ena_out  output  1  out valid
rdy_in  input  1  downstream accepts out
marker  output  8  marker code (byte following an unstuffed 0xFF)
marker_valid  output  1  one-cycle pulse, marker valid
done  output  1  one-cycle pulse on EOI
error  output  1  sticky protocol error

Behaviour:
- Only clock is clk. Reset is synchronous, active-high, on rst.
- Transfers:
  - Input word transfers on a clk edge with ena_in && rdy_out.
  - Output byte transfers on a clk edge with ena_out && rdy_in.
- Holding register: 2 bytes plus count cnt (0-2).
  - On accept, load cnt = in_valid; in_valid=3 loads 2 and sets error.
  - in_valid=0 is accepted and dropped.
- Advance: adv = (!ena_out || rdy_in) || state==DONE. When adv && cnt>0, process exactly one byte (oldest first) per cycle.
- rdy_out = (cnt==0) || (cnt==1 && adv). Combinational; no combinational path from ena_in.
- State machine, per processed byte b:
  - NORMAL: b!=FF -> emit b. b==FF -> no emit, go SAW_FF.
  - SAW_FF, b==00 -> emit FF, go NORMAL.
  - SAW_FF, b==FF -> fill byte, no emit, stay SAW_FF.
  - SAW_FF, b in D0-D7 (restart) -> marker=b, pulse marker_valid, go NORMAL.
  - SAW_FF, b==EOI_CODE -> marker=b, pulse marker_valid and done in the same cycle, go DONE.
  - SAW_FF, any other b -> marker=b, pulse marker_valid, set error, go NORMAL.
  - DONE: accept and drop all input, never emit. Leave DONE only via rst.
- Emit: out/ena_out are registered.
  - Byte processed at edge E appears with ena_out high after E, i.e. one cycle after processing. First byte of an accepted word is visible two edges after acceptance.
  - With no new emit and the output accepted, ena_out clears.
  - Under backpressure (ena_out && !rdy_in), out is held stable and no byte is processed.
- marker_valid and done are registered single-cycle pulses, independent of rdy_in. A marker byte never asserts ena_out.
- A stream ending in SAW_FF holds state indefinitely; the lone FF is never emitted.
- Word boundaries are transparent: FF at [7:0] followed by 00 at [15:8] of the next word unstuffs to FF.
- Reset values: out=0, ena_out=0, marker=0, marker_valid=0, done=0, error=0, cnt=0, state NORMAL.
- Reset mid-operation discards held bytes and any pending SAW_FF, regardless of rdy_in.
- Throughput: 1 byte/cycle sustained with rdy_in high.

Decomposition:
- Shared package jpeg_pkg:
  - constants MARKER_PREFIX, STUFF_BYTE=8'h00, EOI, RST0/RST7 range bounds
  - state enum {NORMAL, SAW_FF, DONE}
- No sub-module: holding register and FSM are small and tightly coupled.

Test Plan:
- Word 0x1234, in_valid=2, rdy_in=1 -> out 0x12 then 0x34 on consecutive cycles; no marker_valid; error=0.
- Words 0xAAFF, 0x00BB (2 each) -> out AA, FF, BB; stuffed 00 removed across the word boundary.
- Bytes FF FF 00 then 0x55 -> out FF, 55 only (fill byte dropped); FF D3 -> marker=D3, marker_valid 1 cycle, no ena_out; subsequent 0x66 output normally.
- Bytes AB FF D9 then word 0x1234 -> out AB; marker=D9 with marker_valid and done high in the same single cycle; 0x1234 accepted (rdy_out=1) and dropped, ena_out stays 0.
- out=0x12 pending with rdy_in=0 for 3 cycles, second word offered -> out stable 0x12, rdy_out low once cnt=2; after rdy_in=1, bytes drain in order, no loss or duplication.
- FF 01 -> marker=01, error set and sticky; in_valid=3 also sets error; rst asserted mid-stream with cnt=2 and SAW_FF -> next cycle all outputs 0, rdy_out=1, next 0x00 byte emitted as 00, not FF.

Source files
------------

// File: rtl/jpeg_pkg.sv
// Shared definitions for the JPEG decode pipeline.
//   MARKER_PREFIX : byte that introduces a stuffed byte or a marker
//   STUFF_BYTE    : byte the encoder inserts after a data 0xFF
//   EOI           : end-of-image marker code
//   RST0 / RST7   : bounds of the restart-marker code range
//   unstuff_state_e : byte unstuffer scanning state
package jpeg_pkg;

  localparam logic [7:0] MARKER_PREFIX = 8'hFF;
  localparam logic [7:0] STUFF_BYTE    = 8'h00;
  localparam logic [7:0] EOI           = 8'hD9;
  localparam logic [7:0] RST0          = 8'hD0;
  localparam logic [7:0] RST7          = 8'hD7;

  typedef enum logic [1:0] {
    NORMAL = 2'd0,
    SAW_FF = 2'd1,
    DONE   = 2'd2
  } unstuff_state_e;

  function automatic logic is_restart(input logic [7:0] code);
    return (code >= RST0) && (code <= RST7);
  endfunction

endpackage

// File: rtl/byte_unstuffer_if.sv
// Stream signals of the byte unstuffer.
//   Word side (upstream -> unstuffer):
//     in[15:0]      stuffed bytes, first byte in [15:8], second in [7:0]
//     in_valid[1:0] number of valid bytes in the word (3 is illegal)
//     ena_in        word valid
//     rdy_out       unstuffer can accept a word this cycle
//   Byte side (unstuffer -> Huffman decoder):
//     out[7:0]      unstuffed data byte
//     ena_out       out valid
//     rdy_in        downstream accepts out
// The unstuffer uses the slave modport; the source/sink side uses master.
interface byte_unstuffer_if;

  logic [15:0] in;
  logic [1:0]  in_valid;
  logic        ena_in;
  logic        rdy_out;
  logic [7:0]  out;
  logic        ena_out;
  logic        rdy_in;

  modport slave (
    input  in, in_valid, ena_in, rdy_in,
    output rdy_out, out, ena_out
  );

  modport master (
    output in, in_valid, ena_in, rdy_in,
    input  rdy_out, out, ena_out
  );

endinterface

// File: rtl/byte_unstuffer.sv
// First stage of the JPEG decode pipeline. Takes the entropy-coded stream
// as 16-bit words of 0-2 bytes, removes the 0x00 stuffed after each data
// 0xFF, drops 0xFF fill bytes, pulls out marker codes and hands clean data
// bytes, one per cycle, to the Huffman decoder.
//   clk          : clock
//   rst          : synchronous active-high reset
//   bus          : word input / byte output streams (slave modport)
//   marker       : last marker code seen (byte following an unstuffed 0xFF)
//   marker_valid : one-cycle pulse, marker holds a new code
//   done         : one-cycle pulse when the EOI marker is decoded
//   error        : sticky protocol error (illegal in_valid or unknown marker)
module byte_unstuffer #(
  parameter logic [7:0] MARKER_PREFIX = jpeg_pkg::MARKER_PREFIX,
  parameter logic [7:0] EOI_CODE      = jpeg_pkg::EOI
) (
  input  logic                    clk,
  input  logic                    rst,
  byte_unstuffer_if.slave         bus,
  output logic [7:0]              marker,
  output logic                    marker_valid,
  output logic                    done,
  output logic                    error
);

  import jpeg_pkg::*;

  unstuff_state_e state;

  // Two-byte holding register; hold[0] is always the oldest byte.
  logic [7:0] hold [2];
  logic [1:0] cnt;

  logic       out_free;  // output register may take a new byte
  logic       adv;       // a held byte may be consumed this cycle
  logic       proc;      // a held byte is consumed this cycle
  logic       accept;    // an input word is taken this cycle
  logic [7:0] cur;       // byte being consumed

  assign out_free = !bus.ena_out || bus.rdy_in;
  // After EOI nothing is emitted, so backpressure must not stall the drop.
  assign adv      = out_free || (state == DONE);
  assign proc     = adv && (cnt != 2'd0);
  // Accept only when the slot is empty or its last byte leaves this cycle;
  // depends on rdy_in but never on ena_in.
  assign bus.rdy_out = (cnt == 2'd0) || ((cnt == 2'd1) && adv);
  assign accept   = bus.ena_in && bus.rdy_out;
  assign cur      = hold[0];

  // NOTE: the holding bytes are not reset; cnt alone says which are live,
  // so resetting them would only add muxes on the data path.
  always_ff @(posedge clk) begin
    if (accept) begin
      hold[0] <= bus.in[15:8];
      hold[1] <= bus.in[7:0];
    end else if (proc) begin
      hold[0] <= hold[1];
    end
  end

  // NOTE: every register here is assigned with <= so that each read sees
  // the value from before the edge, whatever the statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= NORMAL;
      cnt          <= 2'd0;
      bus.out      <= 8'h00;
      bus.ena_out  <= 1'b0;
      marker       <= 8'h00;
      marker_valid <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
    end else begin
      marker_valid <= 1'b0;
      done         <= 1'b0;
      if (out_free) begin
        bus.ena_out <= 1'b0;
      end

      // rdy_out guarantees the slot is empty (or emptying) on accept.
      if (accept) begin
        cnt <= (bus.in_valid == 2'd3) ? 2'd2 : bus.in_valid;
        if (bus.in_valid == 2'd3) begin
          error <= 1'b1;
        end
      end else if (proc) begin
        cnt <= cnt - 2'd1;
      end

      // Outside DONE, proc implies out_free, so an emit here never
      // overwrites a byte still waiting for the consumer.
      if (proc) begin
        case (state)
          NORMAL: begin
            if (cur == MARKER_PREFIX) begin
              state <= SAW_FF;
            end else begin
              bus.out     <= cur;
              bus.ena_out <= 1'b1;
            end
          end
          SAW_FF: begin
            if (cur == STUFF_BYTE) begin
              bus.out     <= MARKER_PREFIX;
              bus.ena_out <= 1'b1;
              state       <= NORMAL;
            end else if (cur == MARKER_PREFIX) begin
              state <= SAW_FF;  // fill byte
            end else begin
              marker       <= cur;
              marker_valid <= 1'b1;
              if (cur == EOI_CODE) begin
                done  <= 1'b1;
                state <= DONE;
              end else begin
                state <= NORMAL;
                if (!is_restart(cur)) begin
                  error <= 1'b1;
                end
              end
            end
          end
          DONE: begin
            state <= DONE;  // input is consumed and dropped until reset
          end
          default: begin
            state <= NORMAL;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_byte_unstuffer.sv
// Randomised and directed bench for byte_unstuffer. The stimulus side turns
// a byte list into expected data bytes and markers with a whole-stream
// reference model and queues them; an independent monitor compares every
// byte handshake and marker pulse against those queues.
module tb_byte_unstuffer;

  import jpeg_pkg::*;

  typedef logic [7:0] bq_t [$];
  typedef struct {
    logic [7:0] code;
    logic       is_eoi;
  } mk_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] marker;
  logic       marker_valid;
  logic       done;
  logic       error;

  byte_unstuffer_if bus();

  byte_unstuffer dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .marker       (marker),
    .marker_valid (marker_valid),
    .done         (done),
    .error        (error)
  );

  always #5 clk = ~clk;

  logic [7:0] exp_data [$];
  mk_t        exp_mk   [$];
  logic       exp_err;
  int         n_checks = 0;
  int         n_fail   = 0;
  bit         rand_bp  = 1'b0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Whole-stream reference: scan the byte list with lookahead. A 0xFF is
  // followed by any number of 0xFF fills and then a code byte: 0x00 means
  // a data 0xFF, anything else is a marker. A trailing 0xFF with no code
  // produces nothing. EOI ends the image.
  task automatic model(input bq_t bq);
    int i = 0;
    int j;
    logic [7:0] c;
    while (i < bq.size()) begin
      if (bq[i] != 8'hFF) begin
        exp_data.push_back(bq[i]);
        i++;
      end else begin
        j = i + 1;
        while (j < bq.size() && bq[j] == 8'hFF) j++;
        if (j >= bq.size()) break;
        c = bq[j];
        i = j + 1;
        if (c == 8'h00) begin
          exp_data.push_back(8'hFF);
        end else begin
          exp_mk.push_back('{code: c, is_eoi: (c == 8'hD9)});
          if (c == 8'hD9) break;
          if (!(c inside {[8'hD0:8'hD7]})) exp_err = 1'b1;
        end
      end
    end
  endtask

  // Random backpressure, changed on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (rand_bp) bus.rdy_in = ($urandom % 4) != 0;
    end
  end

  // Monitor: samples 1 ns before each rising edge.
  initial begin
    logic       prev_stall;
    logic [7:0] prev_out;
    mk_t        m;
    prev_stall = 1'b0;
    prev_out   = 8'h00;
    forever begin
      @(negedge clk);
      #4;
      if (rst) begin
        prev_stall = 1'b0;
        continue;
      end
      if (prev_stall) begin
        check("bp_hold_valid", {31'd0, bus.ena_out}, 32'd1);
        check("bp_hold_data", {24'd0, bus.out}, {24'd0, prev_out});
      end
      if (bus.ena_out && bus.rdy_in) begin
        check("byte_expected", {31'd0, exp_data.size() != 0}, 32'd1);
        if (exp_data.size() != 0)
          check("data_byte", {24'd0, bus.out}, {24'd0, exp_data.pop_front()});
      end
      prev_stall = bus.ena_out && !bus.rdy_in;
      prev_out   = bus.out;
      if (marker_valid) begin
        check("marker_expected", {31'd0, exp_mk.size() != 0}, 32'd1);
        if (exp_mk.size() != 0) begin
          m = exp_mk.pop_front();
          check("marker_code", {24'd0, marker}, {24'd0, m.code});
          check("done_with_marker", {31'd0, done}, {31'd0, m.is_eoi});
        end
      end else if (done) begin
        check("done_without_marker", {31'd0, marker_valid}, 32'd1);
      end
    end
  end

  // All driver tasks start and end just after a falling edge.
  task automatic wait_accept();
    logic acc;
    int   n = 0;
    forever begin
      #4;
      acc = bus.rdy_out;
      @(negedge clk);
      if (acc) break;
      n++;
      if (n > 500) begin
        check("accept_timeout", {31'd0, acc}, 32'd1);
        break;
      end
    end
  endtask

  task automatic send_word(input logic [15:0] w, input logic [1:0] v);
    bus.in       = w;
    bus.in_valid = v;
    bus.ena_in   = 1'b1;
    wait_accept();
  endtask

  task automatic idle(input int n);
    bus.ena_in = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic apply_reset();
    bus.ena_in = 1'b0;
    rand_bp    = 1'b0;
    bus.rdy_in = 1'b1;
    rst        = 1'b1;
    exp_data.delete();
    exp_mk.delete();
    exp_err = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #4;
    check("rst_out", {24'd0, bus.out}, 32'd0);
    check("rst_ena_out", {31'd0, bus.ena_out}, 32'd0);
    check("rst_marker", {24'd0, marker}, 32'd0);
    check("rst_marker_valid", {31'd0, marker_valid}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_error", {31'd0, error}, 32'd0);
    check("rst_rdy_out", {31'd0, bus.rdy_out}, 32'd1);
    @(negedge clk);
  endtask

  task automatic wait_drain();
    int n = 0;
    bus.ena_in = 1'b0;
    while ((exp_data.size() + exp_mk.size()) != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("drain", exp_data.size() + exp_mk.size(), 32'd0);
    rand_bp    = 1'b0;
    bus.rdy_in = 1'b1;
    repeat (6) @(negedge clk);  // catch any stray output
    check("error_flag", {31'd0, error}, {31'd0, exp_err});
  endtask

  // Packs a byte list into words of random fill, with optional gaps.
  task automatic send_bytes(input bq_t bq);
    int i = 0;
    int v;
    while (i < bq.size()) begin
      v = $urandom % 3;
      if (v == 0) begin
        send_word(16'($urandom), 2'd0);
      end else if (v == 1 || i == bq.size() - 1) begin
        send_word({bq[i], 8'($urandom)}, 2'd1);
        i++;
      end else begin
        send_word({bq[i], bq[i+1]}, 2'd2);
        i += 2;
      end
      if ($urandom % 4 == 0) idle(1 + $urandom % 3);
    end
    idle(1);
  endtask

  function automatic logic [7:0] rand_byte();
    int r = $urandom % 12;
    if (r < 3) return 8'hFF;
    if (r == 3) return 8'h00;
    if (r == 4) return 8'hD0 + 8'($urandom % 8);
    if (r == 5 && ($urandom % 3) == 0) return 8'hC0 + 8'($urandom % 64);
    return 8'($urandom);
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bq_t bq;
    bus.in       = 16'h0000;
    bus.in_valid = 2'd0;
    bus.ena_in   = 1'b0;
    bus.rdy_in   = 1'b1;
    @(negedge clk);

    // Plain word, both bytes pass through.
    apply_reset();
    bq = '{8'h12, 8'h34};
    model(bq);
    send_word(16'h1234, 2'd2);
    wait_drain();

    // Stuffed zero split across a word boundary.
    apply_reset();
    bq = '{8'hAA, 8'hFF, 8'h00, 8'hBB};
    model(bq);
    send_word(16'hAAFF, 2'd2);
    send_word(16'h00BB, 2'd2);
    wait_drain();

    // Fill byte, restart marker, then normal data.
    apply_reset();
    bq = '{8'hFF, 8'hFF, 8'h00, 8'h55, 8'hFF, 8'hD3, 8'h66};
    model(bq);
    send_word(16'hFFFF, 2'd2);
    send_word(16'h0055, 2'd2);
    send_word(16'hFFD3, 2'd2);
    send_word(16'h6677, 2'd1);
    wait_drain();

    // EOI, then further input is accepted and dropped.
    apply_reset();
    bq = '{8'hAB, 8'hFF, 8'hD9, 8'h12, 8'h34};
    model(bq);
    check("model_eoi_drop", exp_data.size(), 32'd1);
    send_word(16'hABFF, 2'd2);
    send_word(16'hD900, 2'd1);
    send_word(16'h1234, 2'd2);
    wait_drain();

    // Backpressure: first byte held, second word refused, then drain.
    apply_reset();
    bq = '{8'h12, 8'h34, 8'h56, 8'h78};
    model(bq);
    bus.rdy_in = 1'b0;
    send_word(16'h1234, 2'd2);
    bus.in = 16'h5678;
    #4;
    check("bp_rdy_out_full", {31'd0, bus.rdy_out}, 32'd0);
    @(negedge clk);
    repeat (3) begin
      #4;
      check("bp_rdy_out", {31'd0, bus.rdy_out}, 32'd0);
      check("bp_out", {24'd0, bus.out}, 32'h12);
      check("bp_ena_out", {31'd0, bus.ena_out}, 32'd1);
      @(negedge clk);
    end
    bus.rdy_in = 1'b1;
    wait_accept();
    wait_drain();

    // Unknown marker sets error, which stays set.
    apply_reset();
    bq = '{8'hFF, 8'h01, 8'h77};
    model(bq);
    send_word(16'hFF01, 2'd2);
    send_word(16'h7700, 2'd1);
    wait_drain();

    // Illegal in_valid: both bytes kept, error set.
    apply_reset();
    bq = '{8'h11, 8'h22};
    model(bq);
    exp_err = 1'b1;
    send_word(16'h1122, 2'd3);
    wait_drain();

    // Reset while two bytes are held and a 0xFF is pending.
    apply_reset();
    send_word(16'hFF00, 2'd1);
    send_word(16'h0044, 2'd2);
    apply_reset();
    bq = '{8'h00};
    model(bq);
    send_word(16'h0099, 2'd1);
    wait_drain();

    // Random streams under random backpressure.
    for (int seg = 0; seg < 12; seg++) begin
      apply_reset();
      bq.delete();
      for (int k = 0; k < 20 + int'($urandom % 40); k++) bq.push_back(rand_byte());
      if (seg % 3 == 0) begin
        bq.push_back(8'hFF);
        bq.push_back(8'hD9);
        for (int k = 0; k < 6; k++) bq.push_back(rand_byte());
      end
      model(bq);
      rand_bp = 1'b1;
      send_bytes(bq);
      wait_drain();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
